// File: rtl/nes_rom_if.sv
// Loader/reader bundle for the NROM cartridge store.
// master: loader and CPU/PPU side that drives the stream and addresses.
// slave:  cartridge store that accepts the stream and returns read data.
interface nes_rom_if;
  logic        prog;
  logic        prog_we;
  logic [7:0]  prog_di;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic [15:0] ppu_ab;
  logic [7:0]  ppu_do;
  logic        loaded;
  logic        load_err;

  modport master (
    output prog, prog_we, prog_di, cpu_ab, ppu_ab,
    input  cpu_do, ppu_do, loaded, load_err
  );

  modport slave (
    input  prog, prog_we, prog_di, cpu_ab, ppu_ab,
    output cpu_do, ppu_do, loaded, load_err
  );
endinterface

// File: rtl/nes_rom_master.sv
// NROM cartridge store: accepts an iNES byte stream, validates the header,
// fills PRG/CHR RAM and then serves registered CPU (PRG) and PPU (CHR) reads.
// Optional build macro NROM256_EN: 32KB PRG RAM, header PRG units may be 1 or 2,
// and a 2-unit image maps PRG linearly over 8000-FFFF without mirroring.
module nes_rom_master #(
  parameter int PRG_KB  = 16,
  parameter int CHR_KB  = 8,
  parameter int HDR_LEN = 16
) (
  input logic      nios_clk,
  input logic      rst,
  nes_rom_if.slave bus
);

  localparam int PRG_BYTES = PRG_KB * 1024;
  localparam int CHR_BYTES = CHR_KB * 1024;
  localparam int PRG_AW    = $clog2(PRG_BYTES);
  localparam int CHR_AW    = $clog2(CHR_BYTES);
`ifdef NROM256_EN
  localparam int PRG_DEPTH = 2 * PRG_BYTES;
  localparam int PRG_RAW   = PRG_AW + 1;
`else
  localparam int PRG_DEPTH = PRG_BYTES;
  localparam int PRG_RAW   = PRG_AW;
`endif

  localparam logic [15:0] HDR_LAST     = 16'(HDR_LEN - 1);
  localparam logic [15:0] PRG_LAST_ONE = 16'(HDR_LEN + PRG_BYTES - 1);
  localparam logic [15:0] PRG_LAST_TWO = 16'(HDR_LEN + 2 * PRG_BYTES - 1);
  localparam logic [15:0] HDR_BASE     = 16'(HDR_LEN);

  typedef enum logic [2:0] {IDLE, HEADER, PRG, CHR, DONE, ERROR} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        loaded_q;
  logic        load_err_q;
  logic        prog_q;
  logic        big_prg;
  logic [7:0]  cpu_do_q;
  logic [7:0]  ppu_do_q;

  logic [7:0]  prg_mem [PRG_DEPTH];
  logic [7:0]  chr_mem [CHR_BYTES];

  // Header bytes 0..5 carry the magic and unit counts; the rest are don't-care.
  function automatic logic hdr_byte_ok(input logic [15:0] idx, input logic [7:0] b);
    case (idx)
      16'd0:   return b == 8'h4E;
      16'd1:   return b == 8'h45;
      16'd2:   return b == 8'h53;
      16'd3:   return b == 8'h1A;
`ifdef NROM256_EN
      16'd4:   return (b == 8'd1) || (b == 8'd2);
`else
      16'd4:   return b == 8'd1;
`endif
      16'd5:   return b == 8'd1;
      default: return 1'b1;
    endcase
  endfunction

  logic                byte_in;
  logic                rd_en;
  logic [15:0]         prg_last;
  logic [15:0]         chr_base;
  logic [15:0]         chr_last;
  logic [15:0]         prg_off;
  logic [15:0]         chr_off;
  logic                prg_wr;
  logic                chr_wr;
  logic [PRG_RAW-1:0]  cpu_idx;

`ifndef NROM256_EN
  assign big_prg = 1'b0;
`endif

  // Phase boundaries, write strobes and the CPU read index.
  always_comb begin
    byte_in  = bus.prog && bus.prog_we;
    rd_en    = !bus.prog && loaded_q;
    prg_last = big_prg ? PRG_LAST_TWO : PRG_LAST_ONE;
    chr_base = prg_last + 16'd1;
    chr_last = chr_base + 16'(CHR_BYTES - 1);
    prg_off  = cnt - HDR_BASE;
    chr_off  = cnt - chr_base;
    // Reset has priority over the stream, so a byte arriving with rst is dropped.
    prg_wr   = !rst && byte_in && (state == PRG);
    chr_wr   = !rst && byte_in && (state == CHR);
`ifdef NROM256_EN
    cpu_idx  = big_prg ? bus.cpu_ab[PRG_AW:0] : {1'b0, bus.cpu_ab[PRG_AW-1:0]};
`else
    cpu_idx  = bus.cpu_ab[PRG_AW-1:0];
`endif
  end

  // Load-session FSM: tracks the byte counter, phase and the loaded/error flags.
  always_ff @(posedge nios_clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      loaded_q   <= 1'b0;
      load_err_q <= 1'b0;
      prog_q     <= 1'b0;
`ifdef NROM256_EN
      big_prg    <= 1'b0;
`endif
    end else begin
      // NOTE: every register here is state, so each update is non-blocking; the
      // comparisons below all see the values from before this edge.
      prog_q <= bus.prog;
      case (state)
        IDLE: begin
          if (bus.prog) begin
            state      <= HEADER;
            cnt        <= '0;
            loaded_q   <= 1'b0;
            load_err_q <= 1'b0;
`ifdef NROM256_EN
            big_prg    <= 1'b0;
`endif
          end
        end
        HEADER: begin
          if (!bus.prog) begin
            state    <= IDLE;
            loaded_q <= 1'b0;
          end else if (bus.prog_we) begin
            cnt <= cnt + 16'd1;
            if (!hdr_byte_ok(cnt, bus.prog_di)) begin
              state      <= ERROR;
              load_err_q <= 1'b1;
            end else if (cnt == HDR_LAST) begin
              state <= PRG;
            end
`ifdef NROM256_EN
            if (cnt == 16'd4) big_prg <= (bus.prog_di == 8'd2);
`endif
          end
        end
        PRG: begin
          if (!bus.prog) begin
            state    <= IDLE;
            loaded_q <= 1'b0;
          end else if (bus.prog_we) begin
            cnt <= cnt + 16'd1;
            if (cnt == prg_last) state <= CHR;
          end
        end
        CHR: begin
          if (!bus.prog) begin
            state    <= IDLE;
            loaded_q <= 1'b0;
          end else if (bus.prog_we) begin
            cnt <= cnt + 16'd1;
            if (cnt == chr_last) begin
              state    <= DONE;
              loaded_q <= 1'b1;
            end
          end
        end
        DONE: begin
          // A rising prog starts a fresh session; a byte during the same session overruns.
          if (bus.prog && !prog_q) begin
            state      <= HEADER;
            cnt        <= '0;
            loaded_q   <= 1'b0;
            load_err_q <= 1'b0;
`ifdef NROM256_EN
            big_prg    <= 1'b0;
`endif
          end else if (byte_in) begin
            cnt        <= cnt + 16'd1;
            state      <= ERROR;
            loaded_q   <= 1'b0;
            load_err_q <= 1'b1;
          end
        end
        ERROR: begin
          if (!bus.prog) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Image RAM writes.
  // NOTE: the RAM arrays are deliberately not reset so they map onto block RAM;
  // the loaded flag keeps stale contents from ever reaching the read ports.
  always_ff @(posedge nios_clk) begin
    if (prg_wr) prg_mem[prg_off[PRG_RAW-1:0]] <= bus.prog_di;
    if (chr_wr) chr_mem[chr_off[CHR_AW-1:0]]  <= bus.prog_di;
  end

  // Registered CPU/PPU read ports, forced to zero outside a valid image window.
  always_ff @(posedge nios_clk) begin
    if (rst) begin
      cpu_do_q <= 8'h00;
      ppu_do_q <= 8'h00;
    end else begin
      cpu_do_q <= (rd_en && bus.cpu_ab[15]) ? prg_mem[cpu_idx] : 8'h00;
      ppu_do_q <= (rd_en && (bus.ppu_ab[15:CHR_AW] == '0))
                  ? chr_mem[bus.ppu_ab[CHR_AW-1:0]] : 8'h00;
    end
  end

  assign bus.cpu_do   = cpu_do_q;
  assign bus.ppu_do   = ppu_do_q;
  assign bus.loaded   = loaded_q;
  assign bus.load_err = load_err_q;

  // Address bits that the selected mapping does not decode.
  logic unused_bits;
  assign unused_bits = ^{bus.cpu_ab[14:PRG_AW], prg_off[15:PRG_RAW], chr_off[15:CHR_AW]};

endmodule

// File: tb/tb_nes_rom_master.sv
// Directed bench for nes_rom_master: full loads, bad header, abort, overrun,
// reset during CHR, plus a table of read-port vectors after a good load.
module tb_nes_rom_master;

  logic nios_clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  nes_rom_if bus ();

  nes_rom_master dut (
    .nios_clk (nios_clk),
    .rst      (rst),
    .bus      (bus)
  );

  initial nios_clk = 1'b0;
  always #5 nios_clk = ~nios_clk;

  typedef struct {
    logic [15:0] cpu_ab;
    logic [15:0] ppu_ab;
    logic [7:0]  exp_cpu;
    logic [7:0]  exp_ppu;
  } rd_vec_t;

  rd_vec_t vecs [8];

  task automatic tick();
    @(posedge nios_clk);
    @(negedge nios_clk);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Reference image: PRG[i]=i[7:0] (xor i[15:8] for 2-unit images), CHR[i]=~i[7:0].
  function automatic logic [7:0] img_byte(input int idx, input int units);
    int prg_end;
    int i;
    logic [15:0] iv;
    prg_end = 16 + units * 16384;
    if (idx < 16) begin
      case (idx)
        0: return 8'h4E;
        1: return 8'h45;
        2: return 8'h53;
        3: return 8'h1A;
        4: return 8'(units);
        5: return 8'h01;
        default: return 8'h00;
      endcase
    end else if (idx < prg_end) begin
      i  = idx - 16;
      iv = 16'(i);
      return (units == 2) ? (iv[7:0] ^ iv[15:8]) : iv[7:0];
    end else begin
      i  = idx - prg_end;
      iv = 16'(i);
      return ~iv[7:0];
    end
  endfunction

  task automatic begin_session();
    bus.prog    = 1'b1;
    bus.prog_we = 1'b0;
    tick();
  endtask

  task automatic stream(input int from, input int to_excl, input int units);
    for (int i = from; i < to_excl; i++) begin
      bus.prog_we = 1'b1;
      bus.prog_di = img_byte(i, units);
      tick();
    end
    bus.prog_we = 1'b0;
  endtask

  task automatic read_pair(input logic [15:0] ca, input logic [15:0] pa);
    bus.cpu_ab = ca;
    bus.ppu_ab = pa;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst         = 1'b1;
    bus.prog    = 1'b0;
    bus.prog_we = 1'b0;
    bus.prog_di = 8'h00;
    bus.cpu_ab  = 16'h8005;
    bus.ppu_ab  = 16'h0003;

    vecs[0] = '{16'h8005, 16'h0003, 8'h05, 8'hFC};
    vecs[1] = '{16'hC005, 16'h1FFE, 8'h05, 8'h01};
    vecs[2] = '{16'h4000, 16'h2000, 8'h00, 8'h00};
    vecs[3] = '{16'hFFFF, 16'h0000, 8'hFF, 8'hFF};
    vecs[4] = '{16'h8000, 16'hE003, 8'h00, 8'h00};
    vecs[5] = '{16'h7FFF, 16'h00AB, 8'h00, 8'h54};
    vecs[6] = '{16'hBFFE, 16'h1234, 8'hFE, 8'hCB};
    vecs[7] = '{16'hC0C3, 16'h0FF0, 8'hC3, 8'h0F};

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_loaded",   8'(bus.loaded),   8'h00);
    check("rst_load_err", 8'(bus.load_err), 8'h00);
    check("rst_cpu_do",   bus.cpu_do,       8'h00);
    check("rst_ppu_do",   bus.ppu_do,       8'h00);

    // 1: full valid image, drop prog, table-driven reads
    begin_session();
    stream(0, 'h6010, 1);
    check("t1_loaded_at_end", 8'(bus.loaded), 8'h01);
    bus.prog = 1'b0;
    tick();
    check("t1_loaded",   8'(bus.loaded),   8'h01);
    check("t1_load_err", 8'(bus.load_err), 8'h00);
    for (int v = 0; v < 8; v++) begin
      read_pair(vecs[v].cpu_ab, vecs[v].ppu_ab);
      check($sformatf("t1_cpu_%04h", vecs[v].cpu_ab), bus.cpu_do, vecs[v].exp_cpu);
      check($sformatf("t1_ppu_%04h", vecs[v].ppu_ab), bus.ppu_do, vecs[v].exp_ppu);
    end

    // 2: bad magic byte 2, new session started from DONE
    begin_session();
    check("t2_loaded_cleared", 8'(bus.loaded), 8'h00);
    stream(0, 2, 1);
    bus.prog_we = 1'b1;
    bus.prog_di = 8'h54;
    tick();
    check("t2_load_err", 8'(bus.load_err), 8'h01);
    stream(3, 40, 1);
    check("t2_err_sticky", 8'(bus.load_err), 8'h01);
    check("t2_loaded",     8'(bus.loaded),   8'h00);
    bus.prog = 1'b0;
    tick();
    check("t2_state_idle", 8'(int'(dut.state)), 8'h00);
    check("t2_err_held",   8'(bus.load_err),    8'h01);
    read_pair(16'h8005, 16'h0003);
    check("t2_cpu_zero", bus.cpu_do, 8'h00);
    check("t2_ppu_zero", bus.ppu_do, 8'h00);

`ifndef NROM256_EN
    // Header PRG units = 2 is rejected without the NROM256 build
    begin_session();
    check("t2b_err_cleared", 8'(bus.load_err), 8'h00);
    stream(0, 4, 1);
    bus.prog_we = 1'b1;
    bus.prog_di = 8'h02;
    tick();
    bus.prog_we = 1'b0;
    check("t2b_units2_err", 8'(bus.load_err), 8'h01);
    bus.prog = 1'b0;
    tick();
`endif

    // 3: abort after 0x100 bytes, then a full load
    begin_session();
    stream(0, 'h100, 1);
    bus.prog = 1'b0;
    tick();
    check("t3_state_idle", 8'(int'(dut.state)), 8'h00);
    check("t3_loaded",     8'(bus.loaded),      8'h00);
    check("t3_load_err",   8'(bus.load_err),    8'h00);
    begin_session();
    stream(0, 'h6010, 1);
    tick();
    check("t3_reload_loaded", 8'(bus.loaded),   8'h01);
    check("t3_reload_err",    8'(bus.load_err), 8'h00);
    read_pair(16'h8005, 16'h0003);
    check("t3_cpu_gated_by_prog", bus.cpu_do, 8'h00);
    check("t3_ppu_gated_by_prog", bus.ppu_do, 8'h00);

    // 4: overrun byte 0x6010 in the same session
    bus.prog_we = 1'b1;
    bus.prog_di = 8'hAA;
    tick();
    bus.prog_we = 1'b0;
    check("t4_load_err", 8'(bus.load_err), 8'h01);
    check("t4_loaded",   8'(bus.loaded),   8'h00);
    bus.prog = 1'b0;
    tick();
    check("t4_state_idle", 8'(int'(dut.state)), 8'h00);
    check("t4_err_held",   8'(bus.load_err),    8'h01);

    // 5: reset during CHR phase, with a byte strobe in the reset cycle
    begin_session();
    check("t5_err_cleared", 8'(bus.load_err), 8'h00);
    stream(0, 'h4030, 1);
    check("t5_in_chr", 8'(int'(dut.state)), 8'h03);
    bus.cpu_ab  = 16'h8005;
    bus.prog_we = 1'b1;
    bus.prog_di = 8'h55;
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    bus.prog_we = 1'b0;
    bus.prog    = 1'b0;
    check("t5_loaded",     8'(bus.loaded),      8'h00);
    check("t5_cpu_do",     bus.cpu_do,          8'h00);
    check("t5_state_idle", 8'(int'(dut.state)), 8'h00);
    tick();

`ifdef NROM256_EN
    // 6: 32KB image, no mirroring
    begin_session();
    stream(0, 'hA010, 2);
    check("t6_loaded_at_end", 8'(bus.loaded), 8'h01);
    bus.prog = 1'b0;
    tick();
    read_pair(16'hC000, 16'h0003);
    check("t6_cpu_c000", bus.cpu_do, 8'h40);
    check("t6_ppu_0003", bus.ppu_do, 8'hFC);
    read_pair(16'h8000, 16'h0000);
    check("t6_cpu_8000", bus.cpu_do, 8'h00);
    read_pair(16'hFFFF, 16'h0000);
    check("t6_cpu_ffff", bus.cpu_do, 8'h80);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
